// File: rtl/arcade_input_mapper_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : invaders_input_pkg
//  Description : Shared constants for the arcade input mapper. Holds the PS/2
//                set-2 scan codes recognised by the mapper, the joystick bit
//                indices used by both the MiSTer joystick words and the
//                per-player control vectors, and the coin shaper state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package invaders_input_pkg;

    // Player-1 scan codes
    localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
    localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
    localparam logic [7:0] SC_P1_DOWN   = 8'h72;
    localparam logic [7:0] SC_P1_UP     = 8'h75;
    localparam logic [7:0] SC_P1_FIRE_A = 8'h14;
    localparam logic [7:0] SC_P1_FIRE_B = 8'h11;
    localparam logic [7:0] SC_P1_FIRE_C = 8'h29;
    localparam logic [7:0] SC_P1_FIRE_D = 8'h12;

    // Player-2 scan codes
    localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
    localparam logic [7:0] SC_P2_LEFT   = 8'h23;
    localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
    localparam logic [7:0] SC_P2_UP     = 8'h2D;
    localparam logic [7:0] SC_P2_FIRE_A = 8'h1C;
    localparam logic [7:0] SC_P2_FIRE_B = 8'h1B;
    localparam logic [7:0] SC_P2_FIRE_C = 8'h15;
    localparam logic [7:0] SC_P2_FIRE_D = 8'h1D;

    // System scan codes; pairs share a single key bit
    localparam logic [7:0] SC_START1_A  = 8'h05;
    localparam logic [7:0] SC_START1_B  = 8'h16;
    localparam logic [7:0] SC_START2_A  = 8'h06;
    localparam logic [7:0] SC_START2_B  = 8'h1E;
    localparam logic [7:0] SC_COIN_A    = 8'h76;
    localparam logic [7:0] SC_COIN_B1   = 8'h2E;
    localparam logic [7:0] SC_COIN_B2   = 8'h36;

    // Joystick word bit indices (also the control vector layout for [7:0])
    localparam int JOY_RIGHT  = 0;
    localparam int JOY_LEFT   = 1;
    localparam int JOY_DOWN   = 2;
    localparam int JOY_UP     = 3;
    localparam int JOY_FIRE_A = 4;
    localparam int JOY_FIRE_B = 5;
    localparam int JOY_FIRE_C = 6;
    localparam int JOY_FIRE_D = 7;
    localparam int JOY_START1 = 8;
    localparam int JOY_START2 = 9;
    localparam int JOY_COIN   = 10;

    // Coin shaper states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } coin_st_t;

endpackage
`default_nettype wire

// File: rtl/arcade_input_mapper_coin_shaper.sv
`default_nettype none
// ============================================================================
//  Module      : coin_shaper
//  Description : Stretches a raw coin request into a pulse of at least
//                COIN_MIN cycles, follows a longer hold, then forces the
//                output low for at least COIN_GAP cycles before re-arming.
//                The game CPU polls coin at frame rate, so short taps must
//                be widened and bounces must be locked out.
//  Ports       : clk_sys  - system clock
//                reset    - asynchronous active-high reset
//                raw      - unshaped coin request (any source)
//                coin     - shaped, registered coin output
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_shaper
    import invaders_input_pkg::*;
#(
    parameter int COIN_MIN = 240000,
    parameter int COIN_GAP = 120000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic raw,
    output logic coin
);

    localparam int CNT_MAX = (COIN_MIN > COIN_GAP) ? COIN_MIN : COIN_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(COIN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'(COIN_GAP - 1);
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

    coin_st_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             coin_q,  coin_d;

    // coin_d always equals the output for state_d, so the output is a
    // registered Moore output with no decode after the flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        coin_d  = coin_q;
        case (state_q)
            IDLE: begin
                coin_d = 1'b0;
                if (raw) begin
                    state_d = PULSE;
                    cnt_d   = C_PULSE_LOAD;
                    coin_d  = 1'b1;
                end
            end
            PULSE: begin
                coin_d = 1'b1;
                if (cnt_q == '0) begin
                    if (raw) begin
                        state_d = HOLD;
                    end else begin
                        state_d = GAP;
                        cnt_d   = C_GAP_LOAD;
                        coin_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            HOLD: begin
                coin_d = 1'b1;
                if (!raw) begin
                    state_d = GAP;
                    cnt_d   = C_GAP_LOAD;
                    coin_d  = 1'b0;
                end
            end
            GAP: begin
                // Lockout: raw is deliberately ignored here.
                coin_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                coin_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            coin_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
        end
    end

    assign coin = coin_q;

endmodule
`default_nettype wire

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_mapper
//  Description : Tracks PS/2 key state and merges it with the two MiSTer
//                joystick words into registered per-player control vectors,
//                start lines and a shaped coin line.
//  Ports       : clk_sys  - system clock (24 MHz)
//                reset    - asynchronous active-high reset
//                ps2_key  - [10] toggle, [9] pressed, [8] extended, [7:0] code
//                joy1     - player-1 joystick word
//                joy2     - player-2 joystick word
//                p1, p2   - per-player controls {fireD..A, up, down, left, right}
//                p_any    - p1 | p2
//                start1   - start player 1
//                start2   - start player 2
//                coin     - shaped coin pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_mapper
    import invaders_input_pkg::*;
#(
    parameter int COIN_MIN = 240000,
    parameter int COIN_GAP = 120000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy1,
    input  logic [15:0] joy2,
    output logic [7:0]  p1,
    output logic [7:0]  p2,
    output logic [7:0]  p_any,
    output logic        start1,
    output logic        start2,
    output logic        coin
);

    // Event detection state
    logic tog_q;
    logic armed_q;
    logic w_event;

    // Keyboard key-state bits
    logic [7:0] kbd_p1_q, kbd_p1_d;
    logic [7:0] kbd_p2_q, kbd_p2_d;
    logic       kbd_s1_q, kbd_s1_d;
    logic       kbd_s2_q, kbd_s2_d;
    logic       coin_a_q, coin_a_d;
    logic       coin_b_q, coin_b_d;

    // Registered outputs
    logic [7:0] p1_q, p1_d;
    logic [7:0] p2_q, p2_d;
    logic [7:0] p_any_q, p_any_d;
    logic       start1_q, start1_d;
    logic       start2_q, start2_d;

    logic       w_coin_raw;
    logic       w_key_val;
    logic       w_unused_bits;

    // armed_q blocks the first post-reset cycle so a toggle that is already
    // high when reset releases is not mistaken for a new key event.
    assign w_event   = armed_q && (ps2_key[10] != tog_q);
    assign w_key_val = ps2_key[9];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
        end
    end

    // Key decode; the extended flag is intentionally not part of the match.
    always_comb begin
        kbd_p1_d = kbd_p1_q;
        kbd_p2_d = kbd_p2_q;
        kbd_s1_d = kbd_s1_q;
        kbd_s2_d = kbd_s2_q;
        coin_a_d = coin_a_q;
        coin_b_d = coin_b_q;
        if (w_event) begin
            case (ps2_key[7:0])
                SC_P1_RIGHT:  kbd_p1_d[JOY_RIGHT]  = w_key_val;
                SC_P1_LEFT:   kbd_p1_d[JOY_LEFT]   = w_key_val;
                SC_P1_DOWN:   kbd_p1_d[JOY_DOWN]   = w_key_val;
                SC_P1_UP:     kbd_p1_d[JOY_UP]     = w_key_val;
                SC_P1_FIRE_A: kbd_p1_d[JOY_FIRE_A] = w_key_val;
                SC_P1_FIRE_B: kbd_p1_d[JOY_FIRE_B] = w_key_val;
                SC_P1_FIRE_C: kbd_p1_d[JOY_FIRE_C] = w_key_val;
                SC_P1_FIRE_D: kbd_p1_d[JOY_FIRE_D] = w_key_val;
                SC_P2_RIGHT:  kbd_p2_d[JOY_RIGHT]  = w_key_val;
                SC_P2_LEFT:   kbd_p2_d[JOY_LEFT]   = w_key_val;
                SC_P2_DOWN:   kbd_p2_d[JOY_DOWN]   = w_key_val;
                SC_P2_UP:     kbd_p2_d[JOY_UP]     = w_key_val;
                SC_P2_FIRE_A: kbd_p2_d[JOY_FIRE_A] = w_key_val;
                SC_P2_FIRE_B: kbd_p2_d[JOY_FIRE_B] = w_key_val;
                SC_P2_FIRE_C: kbd_p2_d[JOY_FIRE_C] = w_key_val;
                SC_P2_FIRE_D: kbd_p2_d[JOY_FIRE_D] = w_key_val;
                SC_START1_A, SC_START1_B: kbd_s1_d = w_key_val;
                SC_START2_A, SC_START2_B: kbd_s2_d = w_key_val;
                SC_COIN_A:                coin_a_d = w_key_val;
                SC_COIN_B1, SC_COIN_B2:   coin_b_d = w_key_val;
                default: ;
            endcase
        end
    end

    // Output merge: keyboard and joystick sources are simply OR-ed, so a
    // key release never masks a joystick press of the same function.
    always_comb begin
        p1_d     = kbd_p1_q | joy1[7:0];
        p2_d     = kbd_p2_q | joy2[7:0];
        p_any_d  = p1_d | p2_d;
        start1_d = kbd_s1_q | joy1[JOY_START1] | joy2[JOY_START1];
        start2_d = kbd_s2_q | joy1[JOY_START2] | joy2[JOY_START2];
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            kbd_p1_q <= '0;
            kbd_p2_q <= '0;
            kbd_s1_q <= 1'b0;
            kbd_s2_q <= 1'b0;
            coin_a_q <= 1'b0;
            coin_b_q <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            p_any_q  <= '0;
            start1_q <= 1'b0;
            start2_q <= 1'b0;
        end else begin
            kbd_p1_q <= kbd_p1_d;
            kbd_p2_q <= kbd_p2_d;
            kbd_s1_q <= kbd_s1_d;
            kbd_s2_q <= kbd_s2_d;
            coin_a_q <= coin_a_d;
            coin_b_q <= coin_b_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p_any_q  <= p_any_d;
            start1_q <= start1_d;
            start2_q <= start2_d;
        end
    end

    // Coin request feeds the shaper directly; the shaper's own register
    // provides the output stage.
    assign w_coin_raw = coin_a_q | coin_b_q | joy1[JOY_COIN] | joy2[JOY_COIN];

    coin_shaper #(
        .COIN_MIN (COIN_MIN),
        .COIN_GAP (COIN_GAP)
    ) u_coin_shaper (
        .clk_sys (clk_sys),
        .reset   (reset),
        .raw     (w_coin_raw),
        .coin    (coin)
    );

    // Inputs that carry no function in this mapper.
    assign w_unused_bits = ^{ps2_key[8], joy1[15:11], joy2[15:11]};

    assign p1     = p1_q;
    assign p2     = p2_q;
    assign p_any  = p_any_q;
    assign start1 = start1_q;
    assign start2 = start2_q;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arcade_input_mapper
//  Description : Directed self-checking bench for arcade_input_mapper with
//                COIN_MIN=8 and COIN_GAP=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arcade_input_mapper;

    logic        clk_sys;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joy1;
    logic [15:0] joy2;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [7:0]  p_any;
    logic        start1;
    logic        start2;
    logic        coin;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    arcade_input_mapper #(
        .COIN_MIN (8),
        .COIN_GAP (4)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .joy1    (joy1),
        .joy2    (joy2),
        .p1      (p1),
        .p2      (p2),
        .p_any   (p_any),
        .start1  (start1),
        .start2  (start2),
        .coin    (coin)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Everything is driven and sampled 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    // One-cycle joystick coin tap; expects exactly 8 high then >=4 low.
    task automatic coin_tap(input string tag);
        joy1 = 16'h0400;
        chk({tag, "_pre"}, {7'd0, coin}, 8'h00);
        tick();
        joy1 = 16'h0000;
        chk({tag, "_rise"}, {7'd0, coin}, 8'h01);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk({tag, "_high"}, {7'd0, coin}, 8'h01);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_gap"}, {7'd0, coin}, 8'h00);
        end
    endtask

    initial begin
        reset   = 1'b1;
        ps2_key = 11'h400;
        joy1    = 16'h0000;
        joy2    = 16'h0000;
        repeat (2) tick();
        chk("reset_p1",    p1,    8'h00);
        chk("reset_p2",    p2,    8'h00);
        chk("reset_p_any", p_any, 8'h00);
        chk("reset_sys",   {5'd0, start1, start2, coin}, 8'h00);

        // Toggle held high out of reset: no event.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("tog_high_quiet", p1 | p2 | p_any | {5'd0, start1, start2, coin}, 8'h00);
        end

        // Extended right arrow press/release: two-cycle latency.
        key(1'b1, 1'b1, 8'h74);
        tick();
        chk("arrow_lat1", p1, 8'h00);
        tick();
        chk("arrow_press", p1, 8'h01);
        key(1'b0, 1'b1, 8'h74);
        tick();
        tick();
        chk("arrow_release", p1, 8'h00);

        // Player-2 key 1C with joy1 fireA held.
        joy1 = 16'h0010;
        key(1'b1, 1'b0, 8'h1C);
        tick();
        tick();
        chk("p2key_p2",    p2,    8'h10);
        chk("p2key_p1",    p1,    8'h10);
        chk("p2key_p_any", p_any, 8'h10);
        key(1'b0, 1'b0, 8'h1C);
        tick();
        tick();
        chk("p2rel_p2",    p2,    8'h00);
        chk("p2rel_p1",    p1,    8'h10);
        chk("p2rel_p_any", p_any, 8'h10);
        joy1 = 16'h0000;
        tick();
        chk("joy1_release", p1, 8'h00);

        // Key release while joystick holds the same bit keeps it at 1.
        joy2 = 16'h0001;
        key(1'b1, 1'b0, 8'h34);
        tick();
        tick();
        chk("same_bit_press", p2, 8'h01);
        key(1'b0, 1'b0, 8'h34);
        tick();
        tick();
        chk("same_bit_keyrel", p2, 8'h01);
        joy2 = 16'h0000;
        tick();
        chk("same_bit_joyrel", p2, 8'h00);

        // Back-to-back events on consecutive cycles.
        key(1'b1, 1'b0, 8'h74);
        tick();
        key(1'b1, 1'b0, 8'h6B);
        tick();
        tick();
        chk("b2b_press", p1, 8'h03);
        key(1'b1, 1'b0, 8'h6B);
        tick();
        tick();
        chk("repress_idem", p1, 8'h03);
        key(1'b0, 1'b0, 8'h74);
        tick();
        key(1'b0, 1'b0, 8'h6B);
        tick();
        tick();
        chk("b2b_release", p1, 8'h00);

        // Unmatched scan code is a no-op.
        key(1'b1, 1'b0, 8'h99);
        tick();
        tick();
        chk("unmatched", p1 | p2 | {6'd0, start1, start2}, 8'h00);

        // Shared start1 bit: press 16, release via 05.
        key(1'b1, 1'b0, 8'h16);
        tick();
        tick();
        chk("start1_key", {7'd0, start1}, 8'h01);
        key(1'b0, 1'b0, 8'h05);
        tick();
        tick();
        chk("start1_shared_rel", {7'd0, start1}, 8'h00);
        joy2 = 16'h0200;
        tick();
        chk("start2_joy2", {6'd0, start1, start2}, 8'h01);
        joy2 = 16'h0000;
        tick();
        chk("start2_joy2_rel", {7'd0, start2}, 8'h00);

        // Short coin tap.
        coin_tap("tap");

        // Held coin key 76 for 20 cycles.
        key(1'b1, 1'b0, 8'h76);
        tick();
        chk("hold_lat", {7'd0, coin}, 8'h00);
        tick();
        chk("hold_rise", {7'd0, coin}, 8'h01);
        for (int i = 0; i < 18; i++) begin
            tick();
            chk("hold_high", {7'd0, coin}, 8'h01);
        end
        key(1'b0, 1'b0, 8'h76);
        tick();
        chk("hold_rel_edge", {7'd0, coin}, 8'h01);
        tick();
        chk("hold_fall", {7'd0, coin}, 8'h00);
        // Re-press inside the gap: ignored until IDLE, then a new pulse.
        key(1'b1, 1'b0, 8'h76);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_lockout", {7'd0, coin}, 8'h00);
        end
        tick();
        chk("gap_repulse", {7'd0, coin}, 8'h01);
        key(1'b0, 1'b0, 8'h76);
        tick();
        chk("repulse_min_width", {7'd0, coin}, 8'h01);
        repeat (14) tick();
        chk("repulse_done", {7'd0, coin}, 8'h00);

        // Reset mid-pulse drops coin asynchronously.
        joy1 = 16'h0400;
        tick();
        joy1 = 16'h0000;
        tick();
        chk("mid_pulse_high", {7'd0, coin}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_coin", {7'd0, coin}, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_quiet", p1 | p2 | p_any | {5'd0, start1, start2, coin}, 8'h00);
        coin_tap("tap_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
